button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Input-side counterpart to the LED output path on the ULX3S-class board: conditions the raw push-button pins into clean, clock-synchronous events.
- Per button, it provides:
  - two-flop synchronisation;
  - polarity normalisation;
  - a debounce state machine;
  - a debounced level;
  - one-cycle press, release and long-press pulses.
- Sits between the board's button pins and the user logic (LED, counter and menu logic) in the top level.

Parameters:
- N_BTN, 7, number of button channels.
- BTN_INV, 7'b0000001, per-channel inversion mask; bit=1 means the pin is active-low (the power button).
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level change (10 ms at 25 MHz). Must be >= 2.
- LONG_CYCLES, 25000000, hold time in cycles, measured from the accepted press, before long_press fires (1 s). Must be > DEBOUNCE_CYCLES.

Ports:
- clk_25mhz  in   1      25 MHz system clock; all logic on the rising edge.
- rst_n      in   1      asynchronous active-low reset; assertion is asynchronous, release is used as-is (the top-level provides a synchronised deassertion).
- btn        in   N_BTN  raw button pins, asynchronous to clk_25mhz.
- level      out  N_BTN  debounced pressed state; 1 = pressed.
- press      out  N_BTN  1-cycle pulse when a press is accepted.
- release    out  N_BTN  1-cycle pulse when a release is accepted.
- long_press out  N_BTN  1-cycle pulse, at most once per press, after LONG_CYCLES of hold.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - level, press, release and long_press are all 0.
  - Every channel FSM is in RELEASED with its counters at 0.
  - Sync flops load BTN_INV[i], so the normalised input reads "not pressed".
- Synchronisation: btn[i] passes through 2 flops, then is XORed with BTN_INV[i] to give s[i] (1 = pressed).
- Counters:
  - db_cnt is sized for DEBOUNCE_CYCLES-1.
  - hold_cnt is sized for LONG_CYCLES-1 and saturates there.
  - long_done is 1 bit.
- Channel FSM, all outputs registered:
  - RELEASED: s=1 -> DB_PRESS, db_cnt=0.
  - DB_PRESS:
    - s=0 -> RELEASED; the bounce is discarded with no pulse.
    - Otherwise, if db_cnt==DEBOUNCE_CYCLES-1 -> PRESSED. In the same transition: press=1, level=1, hold_cnt=0, long_done=0.
    - Otherwise db_cnt++.
  - PRESSED:
    - hold_cnt++ (saturating).
    - When hold_cnt==LONG_CYCLES-1 and long_done=0: long_press=1, long_done=1.
    - s=0 -> DB_RELEASE, db_cnt=0.
  - DB_RELEASE:
    - hold_cnt keeps counting, and long_press may still fire here.
    - s=1 -> PRESSED, with no pulse and hold_cnt preserved.
    - db_cnt==DEBOUNCE_CYCLES-1 with s=0 -> RELEASED, release=1, level=0.
    - Otherwise db_cnt++.
- Latency:
  - A clean edge on btn produces press/release exactly DEBOUNCE_CYCLES+2 clock edges after the first edge that samples the new pin level (2 sync edges + 1 FSM entry edge + DEBOUNCE_CYCLES-1 counting edges).
  - long_press is asserted LONG_CYCLES edges after press.
- Pulses are high for exactly one cycle. press and release are never high together on one channel.
- Channels are fully independent. Any combination of bits may pulse in the same cycle.
- Button held through reset release: the channel starts in RELEASED, s=1 is seen, and press fires DEBOUNCE_CYCLES+2 edges after the first post-reset sampling edge.
- Reset mid-debounce or mid-hold: all state is lost and no release pulse is emitted.
- Glitches shorter than DEBOUNCE_CYCLES never change level. A bounce restarts db_cnt from 0.

Decomposition:
- Shared package button_pkg holds:
  - btn_state_t enum {RELEASED, DB_PRESS, PRESSED, DB_RELEASE};
  - a clog2-based counter-width helper;
  - default timing constants for 25 MHz.
- Sub-module button_channel contains one synchroniser, FSM and counters. It takes DEBOUNCE_CYCLES, LONG_CYCLES and INV as parameters. button_debouncer is a generate loop of N_BTN instances.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, LONG_CYCLES=20, N_BTN=7, BTN_INV=7'b0000001):
- Reset: hold rst_n=0 with btn random -> all outputs 0. Deassert with btn=7'b0000001, i.e. idle -> no pulses for 50 cycles.
- Clean press and release on btn[1]: rise -> press[1]=1 for 1 cycle exactly 6 edges after the first sampling edge, level[1]=1. Fall after 10 cycles -> release[1] 6 edges later, level[1]=0. long_press[1] stays 0 throughout.
- Bounce on btn[2]: high 3 cycles / low 1 / high 2 / low 1, then steady high -> exactly one press[2], 6 edges after the start of the steady high. No pulse during the bounce.
- Long hold on btn[3]: held 40 cycles -> press[3], then long_press[3] exactly 20 edges later, once only. A 2-cycle release glitch at hold cycle 10 causes no release and does not delay long_press.
- Active-low btn[0]: driven 1->0 -> press[0]. Simultaneously btn[4] and btn[5] rise on the same edge -> press[4] and press[5] pulse in the same cycle.
- Reset mid-operation: assert rst_n at hold cycle 5 on btn[6] -> level[6]=0 immediately. Deassert with the button still held -> press[6] 6 edges later, and no release pulse is emitted.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types, timing defaults and sizing helper for the push-button input path.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_t;

  // Defaults for a 25 MHz clock: 10 ms debounce, 1 s long press.
  localparam int unsigned DEF_N_BTN           = 7;
  localparam logic [6:0]  DEF_BTN_INV         = 7'b0000001;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEF_LONG_CYCLES     = 25000000;

  // Bits needed to hold the values 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchroniser, polarity fix-up, debounce FSM with
// press/release/long-press pulse generation.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter logic        INV             = 1'b0
) (
  input  logic clk_25mhz,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(LONG_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [1:0]        sync_q;
  logic              pressed_c;

  btn_state_t        state_q,     state_d;
  logic [DB_W-1:0]   db_cnt_q,    db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic              long_done_q, long_done_d;
  logic              level_d, press_d, release_d, long_d;

  // Synchroniser resets to the idle pin level so the channel reads "not pressed".
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{INV}};
    end else begin
      sync_q <= {sync_q[0], btn};
    end
  end

  assign pressed_c = sync_q[1] ^ INV;

  // State, counters and registered outputs.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RELEASED;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      long_done_q   <= 1'b0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      long_done_q   <= long_done_d;
      level         <= level_d;
      press         <= press_d;
      release_pulse <= release_d;
      long_press    <= long_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    level_d     = level;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    // Hold timer runs while the button is accepted as down, including release debounce.
    if (state_q == PRESSED || state_q == DB_RELEASE) begin
      if (hold_cnt_q != HOLD_LAST) begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      if (hold_cnt_q == HOLD_LAST && !long_done_q) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end
    end

    unique case (state_q)
      RELEASED: begin
        if (pressed_c) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end
      end
      DB_PRESS: begin
        if (!pressed_c) begin
          state_d = RELEASED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = PRESSED;
          press_d     = 1'b1;
          level_d     = 1'b1;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!pressed_c) begin
          state_d  = DB_RELEASE;
          db_cnt_d = '0;
        end
      end
      DB_RELEASE: begin
        if (pressed_c) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = RELEASED;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
      end
    endcase
  end

endmodule

// File: rtl/button_debouncer.sv
// Board button conditioner: one independent debounce channel per raw pin.
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned       N_BTN           = DEF_N_BTN,
  parameter logic [N_BTN-1:0]  BTN_INV         = N_BTN'(DEF_BTN_INV),
  parameter int unsigned       DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned       LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic             clk_25mhz,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_press
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .INV             (BTN_INV[i])
    ) u_channel (
      .clk_25mhz     (clk_25mhz),
      .rst_n         (rst_n),
      .btn           (btn[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .long_press    (long_press[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: expected pulses are queued with their due cycle as stimulus is driven.
module tb_button_debouncer;

  localparam int unsigned N_BTN = 7;
  localparam int unsigned DB    = 4;
  localparam int unsigned LONG  = 20;
  localparam int          LAT   = 1 + int'(DB) + 2;

  logic             clk_25mhz = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_BTN-1:0] btn = '0;
  logic [N_BTN-1:0] level, press, release_pulse, long_press;

  typedef struct {
    int kind;
    int ch;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  logic [N_BTN-1:0] obs [3];

  button_debouncer #(
    .N_BTN           (N_BTN),
    .BTN_INV         (7'b0000001),
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk_25mhz     (clk_25mhz),
    .rst_n         (rst_n),
    .btn           (btn),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  always #5 clk_25mhz = ~clk_25mhz;

  always @(posedge clk_25mhz) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic string kind_name(input int k);
    case (k)
      0:       return "press";
      1:       return "release";
      default: return "long_press";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input int ch, input int delay);
    exp_q.push_back('{kind, ch, cyc + delay});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  // Every observed pulse must match a queued expectation at its exact cycle.
  always @(posedge clk_25mhz) begin
    #1;
    if (mon_en) begin
      obs[0] = press;
      obs[1] = release_pulse;
      obs[2] = long_press;
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < int'(N_BTN); c++) begin
          if (obs[k][c] === 1'b1) begin
            int found;
            found = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
              if (found < 0 && exp_q[i].kind == k && exp_q[i].ch == c) found = i;
            end
            if (found >= 0) begin
              chk($sformatf("%s[%0d]_cycle", kind_name(k), c), cyc, exp_q[found].cyc);
              exp_q.delete(found);
            end else begin
              chk($sformatf("spurious_%s[%0d]", kind_name(k), c), 1, 0);
            end
          end
        end
      end
    end
  end

  initial begin
    // Reset with random pins: everything quiet.
    for (int r = 0; r < 3; r++) begin
      btn = N_BTN'($urandom);
      step(2);
      chk("rst_outputs", int'({level, press, release_pulse, long_press}), 0);
    end
    btn = 7'b0000001;
    step(1);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step(50);
    chk("idle_level", int'(level), 0);
    chk("idle_pending", exp_q.size(), 0);

    // Clean press / release on btn[1].
    btn[1] = 1'b1;
    expect_ev(0, 1, LAT);
    step(10);
    chk("clean_level_hi", int'(level[1]), 1);
    btn[1] = 1'b0;
    expect_ev(1, 1, LAT);
    step(10);
    chk("clean_level_lo", int'(level[1]), 0);
    chk("clean_pending", exp_q.size(), 0);

    // Bounce on btn[2]: only the steady high is accepted.
    btn[2] = 1'b1; step(3);
    btn[2] = 1'b0; step(1);
    btn[2] = 1'b1; step(2);
    btn[2] = 1'b0; step(1);
    chk("bounce_level", int'(level[2]), 0);
    btn[2] = 1'b1;
    expect_ev(0, 2, LAT);
    step(10);
    chk("bounce_level_hi", int'(level[2]), 1);
    btn[2] = 1'b0;
    expect_ev(1, 2, LAT);
    step(10);
    chk("bounce_pending", exp_q.size(), 0);

    // Long hold on btn[3] with a short release glitch.
    btn[3] = 1'b1;
    expect_ev(0, 3, LAT);
    expect_ev(2, 3, LAT + int'(LONG));
    step(LAT + 10);
    btn[3] = 1'b0; step(2);
    btn[3] = 1'b1;
    step(40 - (LAT + 12));
    chk("long_level_held", int'(level[3]), 1);
    btn[3] = 1'b0;
    expect_ev(1, 3, LAT);
    step(10);
    chk("long_level_lo", int'(level[3]), 0);
    chk("long_pending", exp_q.size(), 0);

    // Active-low btn[0] plus simultaneous btn[4], btn[5].
    btn[0] = 1'b0; btn[4] = 1'b1; btn[5] = 1'b1;
    expect_ev(0, 0, LAT);
    expect_ev(0, 4, LAT);
    expect_ev(0, 5, LAT);
    step(10);
    chk("multi_level", int'(level), 7'b0110001);
    btn[0] = 1'b1; btn[4] = 1'b0; btn[5] = 1'b0;
    expect_ev(1, 0, LAT);
    expect_ev(1, 4, LAT);
    expect_ev(1, 5, LAT);
    step(10);
    chk("multi_level_lo", int'(level), 0);
    chk("multi_pending", exp_q.size(), 0);

    // Reset mid-hold on btn[6]: state lost, no release, re-press after reset.
    btn[6] = 1'b1;
    expect_ev(0, 6, LAT);
    step(LAT + 5);
    chk("rst6_level_before", int'(level[6]), 1);
    rst_n = 1'b0;
    #1;
    chk("rst6_level_async", int'(level[6]), 0);
    step(3);
    rst_n = 1'b1;
    expect_ev(0, 6, LAT);
    step(10);
    chk("rst6_level_hi", int'(level[6]), 1);
    btn[6] = 1'b0;
    expect_ev(1, 6, LAT);
    step(10);
    chk("rst6_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
